// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer with a registered output stage.
// Runtime choice of fixed-select (by i_sel) or round-robin arbitration.
module stream_mux_rr #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 4,
  parameter int SEL_W  = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_mode,
  input  logic [SEL_W-1:0]        i_sel,
  input  logic [NUM_CH*WIDTH-1:0] i_in_data,
  input  logic [NUM_CH-1:0]       i_in_valid,
  output logic [NUM_CH-1:0]       o_in_ready,
  output logic [WIDTH-1:0]        o_out_data,
  output logic                    o_out_valid,
  input  logic                    i_out_ready,
  output logic [SEL_W-1:0]        o_out_ch
);

  logic [WIDTH-1:0]  r_out_data;
  logic              r_out_valid;
  logic [SEL_W-1:0]  r_out_ch;
  logic [SEL_W-1:0]  r_ptr;

  logic              w_load;
  logic [NUM_CH-1:0] w_grant;
  logic [SEL_W-1:0]  w_gnt_idx;
  logic [WIDTH-1:0]  w_gnt_data;
  logic              w_found;
  logic [SEL_W-1:0]  w_scan;
  logic              w_xfer;

  assign w_load = ~r_out_valid | i_out_ready;

  // Out-of-range i_sel never matches any channel index, so it grants nothing.
  always_comb begin
    w_grant    = '0;
    w_gnt_idx  = '0;
    w_gnt_data = '0;
    w_found    = 1'b0;
    w_scan     = '0;
    if (i_mode == 1'b0) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if ((i_sel == SEL_W'(i)) && i_in_valid[i]) begin
          w_grant[i] = 1'b1;
          w_gnt_idx  = SEL_W'(i);
          w_gnt_data = i_in_data[i*WIDTH +: WIDTH];
          w_found    = 1'b1;
        end else begin
          w_grant[i] = w_grant[i];
        end
      end
    end else begin
      for (int k = 1; k <= NUM_CH; k++) begin
        w_scan = SEL_W'((int'(r_ptr) + k) % NUM_CH);
        if (!w_found && i_in_valid[w_scan]) begin
          w_found    = 1'b1;
          w_gnt_idx  = w_scan;
          w_grant[w_scan] = 1'b1;
        end else begin
          w_found = w_found;
        end
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_grant[i]) begin
          w_gnt_data = i_in_data[i*WIDTH +: WIDTH];
        end else begin
          w_gnt_data = w_gnt_data;
        end
      end
    end
  end

  assign o_in_ready = {NUM_CH{w_load}} & w_grant;
  assign w_xfer     = |o_in_ready;

  // New grant wins over a simultaneous drain, so there is no bubble.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_ptr       <= SEL_W'(NUM_CH - 1);
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_gnt_data;
      r_out_ch    <= w_gnt_idx;
      if (i_mode) begin
        r_ptr <= w_gnt_idx;
      end else begin
        r_ptr <= r_ptr;
      end
    end else if (i_out_ready) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_out_valid;
    end
  end

  assign o_out_data  = r_out_data;
  assign o_out_valid = r_out_valid;
  assign o_out_ch    = r_out_ch;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Self-checking bench for stream_mux_rr: directed cases plus randomized traffic
// checked every cycle against a behavioural model.
module tb_stream_mux_rr;
  localparam int W   = 8;
  localparam int NCH = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           mode = 1'b0;
  logic [1:0]     sel = 2'd0;
  logic [NCH*W-1:0] in_data = '0;
  logic [NCH-1:0] in_valid = '0;
  logic [NCH-1:0] in_ready;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [1:0]     out_ch;

  logic           b_mode = 1'b0;
  logic [1:0]     b_sel = 2'd0;
  logic [3*W-1:0] b_in_data = 24'h332211;
  logic [2:0]     b_in_valid = 3'b000;
  logic [2:0]     b_in_ready;
  logic [W-1:0]   b_out_data;
  logic           b_out_valid;
  logic           b_out_ready = 1'b1;
  logic [1:0]     b_out_ch;

  int n_cmp = 0;
  int n_fail = 0;

  // model state
  logic           m_valid;
  logic [W-1:0]   m_data;
  int             m_ch;
  int             m_ptr;
  logic [NCH-1:0] m_ready;
  logic           nx_valid;
  logic [W-1:0]   nx_data;
  int             nx_ch;
  int             nx_ptr;

  always #5 clk = ~clk;

  stream_mux_rr #(.WIDTH(W), .NUM_CH(NCH), .SEL_W(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_mode(mode), .i_sel(sel),
    .i_in_data(in_data), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .o_out_data(out_data), .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out_ch(out_ch)
  );

  stream_mux_rr #(.WIDTH(W), .NUM_CH(3), .SEL_W(2)) dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_mode(b_mode), .i_sel(b_sel),
    .i_in_data(b_in_data), .i_in_valid(b_in_valid), .o_in_ready(b_in_ready),
    .o_out_data(b_out_data), .o_out_valid(b_out_valid), .i_out_ready(b_out_ready),
    .o_out_ch(b_out_ch)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_data = '0; m_ch = 0; m_ptr = NCH - 1; m_ready = '0;
  endtask

  // Grant from the rules: fixed channel, or nearest valid channel after the pointer.
  task automatic model_eval();
    int g;
    int c;
    logic load;
    g = -1;
    if (mode == 1'b0) begin
      if (int'(sel) < NCH && in_valid[sel]) g = int'(sel);
    end else begin
      for (int d = 1; d <= NCH; d++) begin
        c = (m_ptr + d) % NCH;
        if (g < 0 && in_valid[c]) g = c;
      end
    end
    load = !m_valid || out_ready;
    m_ready = '0;
    nx_valid = m_valid; nx_data = m_data; nx_ch = m_ch; nx_ptr = m_ptr;
    if (load && g >= 0) begin
      m_ready[g] = 1'b1;
      nx_valid = 1'b1;
      nx_data = in_data[g*W +: W];
      nx_ch = g;
      if (mode) nx_ptr = g;
    end else if (m_valid && out_ready) begin
      nx_valid = 1'b0;
    end
  endtask

  // One clock: inputs already driven; check readiness, clock, then check outputs.
  task automatic step();
    #1;
    model_eval();
    check("in_ready", 32'(in_ready), 32'(m_ready));
    @(posedge clk);
    m_valid = nx_valid; m_data = nx_data; m_ch = nx_ch; m_ptr = nx_ptr;
    @(negedge clk);
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("out_data", 32'(out_data), 32'(m_data));
    check("out_ch", 32'(out_ch), 32'(m_ch));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_ch", 32'(out_ch), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [NCH-1:0] last_rdy;
    model_reset();
    @(negedge clk);
    do_reset();

    // fixed select of channel 2
    mode = 1'b0; sel = 2'd2; in_valid = 4'hF; out_ready = 1'b1;
    in_data = 32'h44A52211;
    #1;
    check("fix_in_ready", 32'(in_ready), 32'h4);
    step();
    check("fix_data", 32'(out_data), 32'hA5);
    check("fix_ch", 32'(out_ch), 32'd2);

    // asynchronous reset while a word is held
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    do_reset();

    // round-robin with all channels valid
    mode = 1'b1; in_data = 32'h40302010;
    for (int k = 0; k < 8; k++) begin
      step();
      check("rr_ch", 32'(out_ch), 32'(k % 4));
      check("rr_valid", 32'(out_valid), 32'd1);
    end

    // skip and wrap over ch1/ch3 only
    in_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("skip_idle_rdy", 32'(in_ready & 4'b0101), 32'd0);
      step();
      check("skip_ch", 32'(out_ch), (k % 2 == 0) ? 32'd1 : 32'd3);
    end

    // backpressure holds the word and stalls all inputs
    in_valid = 4'hF; out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_in_ready", 32'(in_ready), 32'd0);
      step();
      check("bp_data", 32'(out_data), 32'h40);
    end
    out_ready = 1'b1;
    step();
    check("bp_release_ch", 32'(out_ch), 32'd0);
    check("bp_release_data", 32'(out_data), 32'h10);

    // randomized traffic with stable-until-ready producers
    last_rdy = '1;
    for (int n = 0; n < 600; n++) begin
      for (int c = 0; c < NCH; c++) begin
        if (!in_valid[c] || last_rdy[c]) begin
          in_valid[c] = ($urandom_range(0, 3) != 0);
          in_data[c*W +: W] = W'($urandom);
        end
      end
      out_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      if ($urandom_range(0, 7) == 0) sel = 2'($urandom_range(0, 3));
      step();
      last_rdy = m_ready;
    end

    // out-of-range select on a 3-channel instance
    b_mode = 1'b0; b_sel = 2'd0; b_in_valid = 3'b111; b_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("b_load_valid", 32'(b_out_valid), 32'd1);
    check("b_load_data", 32'(b_out_data), 32'h11);
    b_sel = 2'd3;
    #1;
    check("b_badsel_rdy", 32'(b_in_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("b_drain_valid", 32'(b_out_valid), 32'd0);
    check("b_hold_data", 32'(b_out_data), 32'h11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
